// File: rtl/cpu_pkg.sv
// cpu_pkg: shared command-priority slots and save-stack status type.
// Used by operand_reg (top) and operand_lifo (save stack).
package cpu_pkg;
    localparam int N_UPD    = 6;
    localparam int PRI_DEC  = 0;
    localparam int PRI_INC  = 1;
    localparam int PRI_ZOFF = 2;
    localparam int PRI_OFF  = 3;
    localparam int PRI_IN   = 4;
    localparam int PRI_POP  = 5;
    typedef struct packed {
        logic full;
        logic empty;
    } stk_status_t;
    localparam stk_status_t STK_RESET = '{full: 1'b0, empty: 1'b1};
    function automatic logic multi_hot(input logic [N_UPD-1:0] v);
        return (v & (v - N_UPD'(1))) != '0;
    endfunction
endpackage

// File: rtl/operand_lifo.sv
// operand_lifo: DEPTH-entry save stack for operand_reg.
// Ports: clk, reset (async, active-high), push_i/pop_i (pre-validated by the
// caller, simultaneous push+pop is ignored), din_i (value to save),
// top_o (top entry, combinational), status_o (registered full/empty).
module operand_lifo
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] top_o,
    output stk_status_t       status_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign do_push = push_i && !pop_i && !status_o.full;
    assign do_pop  = pop_i && !push_i && !status_o.empty;
    assign count_d = do_push ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
    assign top_o   = mem_q[AW'(count_q - CW'(1))];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            status_o <= STK_RESET;
        end else begin
            count_q  <= count_d;
            status_o <= '{full: count_d == CW'(DEPTH), empty: count_d == '0};
        end
    end

    // Storage is not reset; only the count defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[count_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/operand_reg.sv
// operand_reg: operand register with bus load/offset load/inc/dec, tri-state
// bus output and an optional save stack (macro OPERAND_REG_STACK_EN).
// Ports: clk, reset (async, active-high), DATA (shared bus, read on load,
// driven on Y_out), REG_OUT (register value), Y_in/Y_offset_in/Y_zoff_in/
// Y_inc/Y_dec/Y_pop (register updates, priority pop>in>off>zoff>inc>dec),
// Y_push (save), Y_out (drive bus), full/empty (stack status),
// err (one-cycle pulse on illegal or conflicting command).
module operand_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OFF_W  = 9,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] DATA,
    output logic [DATA_W-1:0] REG_OUT,
    input  logic              Y_in,
    input  logic              Y_offset_in,
    input  logic              Y_zoff_in,
    input  logic              Y_inc,
    input  logic              Y_dec,
    input  logic              Y_push,
    input  logic              Y_pop,
    input  logic              Y_out,
    output logic              full,
    output logic              empty,
    output logic              err
);
    logic [DATA_W-1:0] reg_q, reg_d, top, off_s, off_z;
    logic              err_q, err_d, pop_ok, stk_err;
    logic [N_UPD-1:0]  upd;
    stk_status_t       stat;

    always_comb begin
        upd           = '0;
        upd[PRI_POP]  = Y_pop;
        upd[PRI_IN]   = Y_in;
        upd[PRI_OFF]  = Y_offset_in;
        upd[PRI_ZOFF] = Y_zoff_in;
        upd[PRI_INC]  = Y_inc;
        upd[PRI_DEC]  = Y_dec;
    end

`ifdef OPERAND_REG_STACK_EN
    operand_lifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (Y_push),
        .pop_i    (Y_pop),
        .din_i    (reg_q),
        .top_o    (top),
        .status_o (stat)
    );
    assign pop_ok  = Y_pop && !Y_push && !stat.empty;
    assign stk_err = (Y_push && Y_pop) || (Y_push && stat.full) || (Y_pop && stat.empty);
`else
    logic unused_cfg;
    assign unused_cfg = Y_push | (DEPTH > 16);
    assign stat       = STK_RESET;
    assign top        = '0;
    assign pop_ok     = 1'b0;
    assign stk_err    = Y_pop;
`endif

    assign off_s = {{(DATA_W-OFF_W){DATA[OFF_W-1]}}, DATA[OFF_W-1:0]};
    assign off_z = {{(DATA_W-OFF_W){1'b0}}, DATA[OFF_W-1:0]};

    // A pop that cannot complete still wins priority, so nothing else updates.
    always_comb begin
        reg_d = upd[PRI_POP]  ? (pop_ok ? top : reg_q) :
                upd[PRI_IN]   ? DATA :
                upd[PRI_OFF]  ? off_s :
                upd[PRI_ZOFF] ? off_z :
                upd[PRI_INC]  ? reg_q + DATA_W'(1) :
                upd[PRI_DEC]  ? reg_q - DATA_W'(1) : reg_q;
        err_d = multi_hot(upd) || stk_err || (Y_out && Y_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_q <= '0;
            err_q <= 1'b0;
        end else begin
            reg_q <= reg_d;
            err_q <= err_d;
        end
    end

    assign DATA    = (Y_out && !reset) ? reg_q : 'z;
    assign REG_OUT = reg_q;
    assign err     = err_q;
    assign full    = stat.full;
    assign empty   = stat.empty;
endmodule

// File: doc/operand_reg.md
OPERAND_REG -- requirements
Module: operand_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus and register width.
REQ-002 SHALL have parameter OFF_W, default 9, offset field width (2..DATA_W-1).
REQ-003 SHALL have parameter DEPTH, default 4, save-stack entries (power of 2, 2..16).
REQ-004 SHALL have port clk  input  1  single clock; state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port DATA  inout  DATA_W  shared bus; read on load, driven on out.
REQ-007 SHALL have port REG_OUT  output  DATA_W  current register value (debug/RAM).
REQ-008 SHALL have port Y_in  input  1  load full DATA.
REQ-009 SHALL have port Y_offset_in  input  1  load DATA[OFF_W-1:0], sign-extended.
REQ-010 SHALL have port Y_zoff_in  input  1  load DATA[OFF_W-1:0], zero-extended.
REQ-011 SHALL have port Y_inc  input  1  register += 1.
REQ-012 SHALL have port Y_dec  input  1  register -= 1.
REQ-013 SHALL have port Y_push  input  1  save register onto stack.
REQ-014 SHALL have port Y_pop  input  1  restore register from stack.
REQ-015 SHALL have port Y_out  input  1  drive register onto DATA.
REQ-016 SHALL have ports full, empty  output  1  stack status.
REQ-017 SHALL have port err  output  1  one-cycle pulse on illegal or conflicting command.

Function
REQ-018 SHALL drive DATA with the register when Y_out=1, high impedance otherwise.
REQ-019 SHALL make REG_OUT combinationally equal to the register.
REQ-020 SHALL give register-update priority: Y_pop > Y_in > Y_offset_in > Y_zoff_in > Y_inc > Y_dec; only the winner takes effect.
REQ-021 SHALL pulse err the cycle after two or more register-update strobes (the pop..dec set) are high together; the winner still executes.
REQ-022 SHALL wrap inc/dec modulo 2^DATA_W (0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF).
REQ-023 SHALL, on Y_push, write the pre-edge register value to the stack top; it may combine with any register-update strobe except Y_pop.
REQ-024 SHALL treat Y_push with Y_pop as a conflict: no stack or register change, err pulses.
REQ-025 SHALL, on Y_push when full, leave the stack unchanged and pulse err; any accompanying register update still executes.
REQ-026 SHALL, on Y_pop when empty, leave the register and stack unchanged and pulse err.
REQ-027 SHALL, on a valid Y_pop, load the top entry into the register in the same edge (1-cycle latency).
REQ-028 SHALL hold a stack count 0..DEPTH; empty = (count==0), full = (count==DEPTH), both registered.
REQ-029 SHALL pulse err if Y_out and Y_in are both high (bus self-loop); the load still executes.

Reset
REQ-030 SHALL asynchronously clear register, stack count and err to 0; empty=1, full=0 while reset is high.
REQ-031 SHALL keep DATA high impedance during reset regardless of Y_out.
REQ-032 SHALL leave stack storage contents undefined after reset; only count matters.

Configuration
REQ-033 SHALL compile the save stack only when macro OPERAND_REG_STACK_EN is defined.
REQ-034 SHALL, without OPERAND_REG_STACK_EN, tie full=0 and empty=1; Y_push is ignored and Y_pop pulses err with no state change.

Structure
REQ-035 SHALL place command-priority constants and the stack-status type in shared package cpu_pkg.
REQ-036 SHALL implement the stack as sub-module operand_lifo (DATA_W, DEPTH), holding storage, count and flags.

Verification
REQ-037 SHALL cover reset mid-push: raise reset while Y_push=1 -> count=0, empty=1, REG_OUT=0x0000 immediately.
REQ-038 SHALL cover sign extension: DATA=0x0100, Y_offset_in -> REG_OUT=0xFF00; DATA=0x00FF, Y_offset_in -> 0x00FF; DATA=0x01FF, Y_zoff_in -> 0x01FF.
REQ-039 SHALL cover wrap: load 0xFFFF, Y_inc -> 0x0000; Y_dec -> 0xFFFF.
REQ-040 SHALL cover stack: push 0x1111..0x4444 (DEPTH=4) -> full=1; 5th push -> err pulse, stack unchanged; 4 pops -> 0x4444,0x3333,0x2222,0x1111, then empty=1; 5th pop -> err, REG_OUT=0x1111.
REQ-041 SHALL cover push+load: REG=0x00AA, DATA=0x5555, Y_push+Y_in -> REG=0x5555; then Y_pop -> REG=0x00AA.
REQ-042 SHALL cover conflicts and tri-state: Y_in+Y_inc with DATA=0x0007 -> REG=0x0007, err=1; Y_out=0 -> DATA reads Z; Y_out=1 -> DATA=REG.
